gppcu_instr_dispatch: RTL and testbench
=======================================

Name: gppcu_instr_dispatch

Overview:
- Instruction issuer feeding the GPPCU core's instruction port.
- On a start pulse, streams a program of iLENGTH words from a synchronous-read instruction memory, starting at iBASE_ADDR.
- Buffers the words in a small prefetch FIFO and presents them on a valid/ready handshake to the core's iINSTR / iINSTR_VALID / oINSTR_READY.
- Sits between the host/program-memory side and GPPCU_CORE; one instance per core.

Parameters:
- DBW, 32, instruction/data width
- ABW, 16, instruction memory address width and length width
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, ≥2)

Ports:
- iACLK  in  1  clock, all logic on rising edge
- iRST  in  1  synchronous reset, active-high
- iSTART  in  1  start request, sampled only in IDLE
- iBASE_ADDR  in  ABW  first instruction address, latched on accepted start
- iLENGTH  in  ABW  instruction count, latched on accepted start
- oBUSY  out  1  high from accepted start until the done cycle inclusive
- oDONE  out  1  one-cycle pulse, program fully handed to core
- oIMEM_ADDR  out  ABW  instruction memory read address
- oIMEM_RD  out  1  read strobe; data returns next cycle
- iIMEM_RDATA  in  DBW  read data, valid exactly 1 cycle after oIMEM_RD
- oINSTR  out  DBW  instruction to core (FIFO head)
- oINSTR_VALID  out  1  FIFO head valid
- iINSTR_READY  in  1  core accepts; handshake = oINSTR_VALID & iINSTR_READY

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0. Reset mid-program flushes the FIFO and drops any in-flight read; no oDONE is produced.
- States:
  - IDLE: iSTART=1 latches base/length, sets oBUSY, and goes to FETCH, or to DONE if length=0.
  - FETCH: issues reads until all fetched, then goes to DRAIN.
  - DRAIN: waits until the final handshake, then goes to DONE.
  - DONE: oDONE=1 and oBUSY=1 for one cycle, then IDLE.
- iSTART is ignored outside IDLE.
- Read issue rule: oIMEM_RD=1 in FETCH when fetched count < length and (FIFO occupancy + in-flight + 1) ≤ FIFO_DEPTH.
  - The FIFO can never overflow; a read may be issued in the same cycle as a pop that frees the slot.
  - oIMEM_ADDR = base + fetched count, modulo 2^ABW (wraps 0xFFFF→0x0000).
- Read data is pushed into the FIFO on the edge ending the cycle after oIMEM_RD.
- Latency: start accepted at edge E0 → oIMEM_RD=1 in cycle after E0 → oINSTR_VALID=1 two cycles later. Start-to-first-valid is 3 cycles.
- Sustained throughput is 1 instruction/cycle when iINSTR_READY is held high (FIFO_DEPTH ≥ 2).
- Handshake:
  - Once asserted, oINSTR_VALID stays high and oINSTR stays stable until the handshake completes.
  - Simultaneous push and pop is allowed at any occupancy, including full and empty+incoming.
- Completion: the handshake of instruction number `length` moves the block to DONE. oDONE is asserted the cycle after that handshake.
- Counters are ABW bits; length = 2^ABW−1 is the maximum program size.

Optional Feature:
- GPPCU_DISPATCH_ABORT_EN defined:
  - Adds input iABORT (1) and output oABORTED (1).
  - iABORT=1 while oBUSY: flush the FIFO, discard the in-flight read response, and deassert oINSTR_VALID the next cycle.
  - Then go to DONE with oDONE=1 and oABORTED=1 for that one cycle.
  - iABORT in IDLE is ignored.
- Undefined: neither port exists; the program always runs to completion or reset.

Decomposition:
- Shared package gppcu_pkg:
  - DBW / ABW constants.
  - Dispatch state encoding (IDLE, FETCH, DRAIN, DONE).
  - Instruction field offsets (COND, OPR, REGD, REGA, REGB, IMM) for use by benches decoding oINSTR.
- One sub-module, gppcu_sync_fifo (parameters DBW, FIFO_DEPTH; push/pop/full/empty/count).
  - Reused later for the GMEM response path.

Test Plan:
- Basic run: base=0x0010, length=3, ready tied 1, memory[a]=0xA000_0000+a → oINSTR 0xA000_0010, 0xA000_0011, 0xA000_0012 on 3 consecutive cycles; first valid 3 cycles after start; oDONE 1 cycle after the last handshake.
- Backpressure: length=8, ready low for 10 cycles, then toggling 1/0 → exactly FIFO_DEPTH reads issued while stalled; oINSTR stable while valid&!ready; all 8 delivered in order, no duplicates.
- Zero length and wrap: length=0 → oDONE 1 cycle after start with no oIMEM_RD. Base=0xFFFE, length=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Start while busy: iSTART pulsed mid-program with a different base → ignored; original sequence completes; a second start after oDONE runs the new program.
- Reset mid-operation: iRST during FETCH with a read in flight and the FIFO holding 2 words → next cycle all outputs 0 and oBUSY=0; the late iIMEM_RDATA is not pushed; no oDONE.
- (ABORT_EN) iABORT at the 2nd handshake of length=6 → valid drops the next cycle; oDONE=oABORTED=1 for one cycle; later reads stop.

Source files
------------

// File: rtl/gppcu_pkg.sv
// Shared GPPCU definitions: widths, dispatch state encoding, instruction fields.
package gppcu_pkg;

   localparam int DBW = 32;
   localparam int ABW = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } dispatch_state_t;

   // IMM overlays REGB in immediate-form instructions
   localparam int COND_LSB = 28;
   localparam int COND_W   = 4;
   localparam int OPR_LSB  = 22;
   localparam int OPR_W    = 6;
   localparam int REGD_LSB = 17;
   localparam int REGD_W   = 5;
   localparam int REGA_LSB = 12;
   localparam int REGA_W   = 5;
   localparam int REGB_LSB = 7;
   localparam int REGB_W   = 5;
   localparam int IMM_LSB  = 0;
   localparam int IMM_W    = 12;

   function automatic logic [DBW-1:0] instr_field(input logic [DBW-1:0] instr,
                                                  input int lsb,
                                                  input int w);
      logic [DBW-1:0] mask;
      mask = (DBW'(1) << w) - DBW'(1);
      return (instr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/gppcu_sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop at any occupancy; rst also serves as flush.
module gppcu_sync_fifo #(
   parameter int DBW        = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [DBW-1:0]              push_data,
   input  logic                        pop,
   output logic [DBW-1:0]              pop_data,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DBW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pop_data = mem[rd_ptr];
   assign do_pop   = pop && !empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push  = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gppcu_instr_dispatch.sv
// Streams a program from synchronous instruction memory to the core via a prefetch FIFO.
// Optional abort support: define GPPCU_DISPATCH_ABORT_EN.
module gppcu_instr_dispatch #(
   parameter int DBW        = gppcu_pkg::DBW,
   parameter int ABW        = gppcu_pkg::ABW,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           iACLK,
   input  logic           iRST,
   input  logic           iSTART,
   input  logic [ABW-1:0] iBASE_ADDR,
   input  logic [ABW-1:0] iLENGTH,
   output logic           oBUSY,
   output logic           oDONE,
   output logic [ABW-1:0] oIMEM_ADDR,
   output logic           oIMEM_RD,
   input  logic [DBW-1:0] iIMEM_RDATA,
   output logic [DBW-1:0] oINSTR,
   output logic           oINSTR_VALID,
   input  logic           iINSTR_READY
`ifdef GPPCU_DISPATCH_ABORT_EN
   ,
   input  logic           iABORT,
   output logic           oABORTED
`endif
);

   import gppcu_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = CW + 1;

   dispatch_state_t state;
   dispatch_state_t state_nx;

   logic [ABW-1:0] base;
   logic [ABW-1:0] length;
   logic [ABW-1:0] fetched;
   logic [ABW-1:0] delivered;
   logic           inflight;

   logic           rd;
   logic           pop;
   logic           flush;
   logic           abort;
   logic           room;
   logic [EW-1:0]  need;
   logic [EW-1:0]  cap;

   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  fifo_count;
   logic [DBW-1:0] fifo_head;

   gppcu_sync_fifo #(
      .DBW        (DBW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (iACLK),
      .rst       (iRST || flush),
      .push      (inflight),
      .push_data (iIMEM_RDATA),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef GPPCU_DISPATCH_ABORT_EN
   logic aborted;

   assign abort    = iABORT && ((state == ST_FETCH) || (state == ST_DRAIN));
   assign oABORTED = aborted && (state == ST_DONE);

   always_ff @(posedge iACLK) begin
      if (iRST) begin
         aborted <= 1'b0;
      end else if (abort) begin
         aborted <= 1'b1;
      end else if (state == ST_DONE) begin
         aborted <= 1'b0;
      end
   end
`else
   assign abort = 1'b0;
`endif

   assign pop = iINSTR_READY && !fifo_empty;

   // slot accounting credits a pop happening this cycle
   assign need = EW'(fifo_count) + EW'(inflight) + EW'(1);
   assign cap  = EW'(FIFO_DEPTH) + EW'(pop);
   assign room = (need <= cap) && (!fifo_full || pop);

   always_comb begin
      state_nx = state;
      rd       = 1'b0;
      flush    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (iSTART) begin
               state_nx = (iLENGTH == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (abort) begin
               flush    = 1'b1;
               state_nx = ST_DONE;
            end else begin
               rd = (fetched < length) && room;
               if (rd && (fetched + ABW'(1) == length)) begin
                  state_nx = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               flush    = 1'b1;
               state_nx = ST_DONE;
            end else if (pop && (delivered + ABW'(1) == length)) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iACLK) begin
      if (iRST) begin
         state     <= ST_IDLE;
         base      <= '0;
         length    <= '0;
         fetched   <= '0;
         delivered <= '0;
         inflight  <= 1'b0;
      end else begin
         state    <= state_nx;
         inflight <= rd;
         if ((state == ST_IDLE) && iSTART) begin
            base      <= iBASE_ADDR;
            length    <= iLENGTH;
            fetched   <= '0;
            delivered <= '0;
         end else begin
            if (rd) begin
               fetched <= fetched + ABW'(1);
            end
            if (pop) begin
               delivered <= delivered + ABW'(1);
            end
         end
      end
   end

   assign oBUSY        = (state != ST_IDLE);
   assign oDONE        = (state == ST_DONE);
   assign oIMEM_RD     = rd;
   assign oIMEM_ADDR   = rd ? (base + fetched) : '0;
   assign oINSTR       = fifo_head;
   assign oINSTR_VALID = !fifo_empty;

endmodule

// File: tb/tb_gppcu_instr_dispatch.sv
// Randomized bench for gppcu_instr_dispatch against a program-level reference model.
module tb_gppcu_instr_dispatch;

   localparam int DBW    = 32;
   localparam int ABW    = 16;
   localparam int DEPTH  = 4;
   localparam int BUDGET = 300;

   logic           iACLK = 1'b0;
   logic           iRST;
   logic           iSTART;
   logic [ABW-1:0] iBASE_ADDR;
   logic [ABW-1:0] iLENGTH;
   logic           oBUSY;
   logic           oDONE;
   logic [ABW-1:0] oIMEM_ADDR;
   logic           oIMEM_RD;
   logic [DBW-1:0] iIMEM_RDATA;
   logic [DBW-1:0] oINSTR;
   logic           oINSTR_VALID;
   logic           iINSTR_READY;
`ifdef GPPCU_DISPATCH_ABORT_EN
   logic           iABORT;
   logic           oABORTED;
`endif

   int checks = 0;
   int errors = 0;
   logic [15:0] mem_tag = 16'hA000;

   always #5 iACLK = ~iACLK;

   gppcu_instr_dispatch #(
      .DBW        (DBW),
      .ABW        (ABW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .iACLK        (iACLK),
      .iRST         (iRST),
      .iSTART       (iSTART),
      .iBASE_ADDR   (iBASE_ADDR),
      .iLENGTH      (iLENGTH),
      .oBUSY        (oBUSY),
      .oDONE        (oDONE),
      .oIMEM_ADDR   (oIMEM_ADDR),
      .oIMEM_RD     (oIMEM_RD),
      .iIMEM_RDATA  (iIMEM_RDATA),
      .oINSTR       (oINSTR),
      .oINSTR_VALID (oINSTR_VALID),
      .iINSTR_READY (iINSTR_READY)
`ifdef GPPCU_DISPATCH_ABORT_EN
      ,
      .iABORT       (iABORT),
      .oABORTED     (oABORTED)
`endif
   );

   // memory word at address a is {tag, a}; junk on the bus when no read was issued
   always @(posedge iACLK) begin
      if (oIMEM_RD) iIMEM_RDATA <= {mem_tag, oIMEM_ADDR};
      else          iIMEM_RDATA <= $urandom;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},  oBUSY, 0);
      check({tag, "_done"},  oDONE, 0);
      check({tag, "_rd"},    oIMEM_RD, 0);
      check({tag, "_addr"},  oIMEM_ADDR, 0);
      check({tag, "_valid"}, oINSTR_VALID, 0);
      check({tag, "_instr"}, oINSTR, 0);
   endtask

   // mode 0: ready high; 1: stall 10 cycles then toggle; 2: random ready; 3: ready high + start while busy
   task automatic run_program(input logic [15:0] base, input logic [15:0] len,
                              input int mode, input logic [15:0] tag);
      logic [31:0] exp_q[$];
      logic [31:0] held;
      int  rd_cnt, hs_cnt, last_hs_k, k;
      bit  fin, stalled, seen_valid;
      mem_tag = tag;
      for (int i = 0; i < int'(len); i++) exp_q.push_back({tag, 16'(base + 16'(i))});
      rd_cnt = 0; hs_cnt = 0; last_hs_k = 0; stalled = 0; seen_valid = 0; held = '0;
      @(posedge iACLK); #1;
      iSTART = 1'b1; iBASE_ADDR = base; iLENGTH = len; iINSTR_READY = 1'b0;
      @(posedge iACLK); #1;
      iSTART = 1'b0;
      k = 1; fin = 0;
      while (!fin) begin
         case (mode)
            1:       iINSTR_READY = (k > 10) ? (k % 2 == 1) : 1'b0;
            2:       iINSTR_READY = ($urandom_range(0, 3) != 0);
            default: iINSTR_READY = 1'b1;
         endcase
         if (mode == 3) begin
            iSTART     = (k == 2);
            iBASE_ADDR = ~base;
            iLENGTH    = len + 16'd5;
         end
         @(negedge iACLK);
         check("busy", oBUSY, 1);
         if (oIMEM_RD) begin
            check("addr", oIMEM_ADDR, 16'(base + 16'(rd_cnt)));
            rd_cnt++;
         end
         if (stalled) begin
            check("hold_valid", oINSTR_VALID, 1);
            check("hold_instr", oINSTR, held);
         end
         if (oINSTR_VALID && !seen_valid) begin
            check("first_valid_cycle", k, 3);
            seen_valid = 1;
         end
         if (oINSTR_VALID && iINSTR_READY) begin
            if (hs_cnt < exp_q.size()) check("instr", oINSTR, exp_q[hs_cnt]);
            else                       check("extra_handshake", hs_cnt, exp_q.size() - 1);
            hs_cnt++;
            last_hs_k = k;
            if (mode == 0 || mode == 3) check("rate", k, 2 + hs_cnt);
         end
         stalled = oINSTR_VALID && !iINSTR_READY;
         held    = oINSTR;
         check("occupancy", (rd_cnt - hs_cnt) <= DEPTH, 1);
         if (mode == 1 && k == 10) check("stall_reads", rd_cnt, DEPTH);
         if (oDONE) begin
            check("done_latency", k, last_hs_k + 1);
            check("hs_total", hs_cnt, len);
            check("rd_total", rd_cnt, len);
            fin = 1;
         end else if (k >= BUDGET) begin
            check("timeout_done", oDONE, 1);
            fin = 1;
         end else begin
            k++;
            @(posedge iACLK); #1;
         end
      end
      iSTART = 1'b0;
      @(posedge iACLK); #1;
      iINSTR_READY = 1'b0;
      @(negedge iACLK);
      check("post_busy", oBUSY, 0);
      check("post_done", oDONE, 0);
   endtask

   task automatic reset_test();
      mem_tag = 16'h5A5A;
      @(posedge iACLK); #1;
      iSTART = 1'b1; iBASE_ADDR = 16'h0100; iLENGTH = 16'd10; iINSTR_READY = 1'b0;
      @(posedge iACLK); #1;
      iSTART = 1'b0;
      repeat (3) @(posedge iACLK);
      #1;
      iRST = 1'b1;
      @(negedge iACLK);
      check("prerst_valid", oINSTR_VALID, 1);
      check("prerst_rd", oIMEM_RD, 1);
      @(posedge iACLK); #1;
      iRST = 1'b0;
      @(negedge iACLK);
      check_idle_outputs("rst_mid");
      repeat (6) begin
         @(negedge iACLK);
         check("rst_after_valid", oINSTR_VALID, 0);
         check("rst_after_done", oDONE, 0);
         check("rst_after_rd", oIMEM_RD, 0);
      end
   endtask

`ifdef GPPCU_DISPATCH_ABORT_EN
   task automatic abort_test();
      mem_tag = 16'hC0DE;
      @(posedge iACLK); #1;
      iSTART = 1'b1; iBASE_ADDR = 16'h0400; iLENGTH = 16'd6; iINSTR_READY = 1'b1;
      @(posedge iACLK); #1;
      iSTART = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         iABORT = (k == 4) || (k == 7);
         @(negedge iACLK);
         if (k == 3 || k == 4) begin
            check("abort_hs_valid", oINSTR_VALID, 1);
            check("abort_hs_instr", oINSTR, {16'hC0DE, 16'(16'h0400 + 16'(k - 3))});
         end
         if (k == 5) begin
            check("abort_valid_drop", oINSTR_VALID, 0);
            check("abort_done", oDONE, 1);
            check("abort_flag", oABORTED, 1);
            check("abort_rd_stop", oIMEM_RD, 0);
         end
         if (k == 6 || k == 7) begin
            check("abort_after_done", oDONE, 0);
            check("abort_after_flag", oABORTED, 0);
            check("abort_after_busy", oBUSY, 0);
            check("abort_after_rd", oIMEM_RD, 0);
         end
         @(posedge iACLK); #1;
      end
      iABORT = 1'b0;
   endtask
`endif

   initial begin
      iRST = 1'b1; iSTART = 1'b0; iBASE_ADDR = '0; iLENGTH = '0; iINSTR_READY = 1'b0;
`ifdef GPPCU_DISPATCH_ABORT_EN
      iABORT = 1'b0;
`endif
      repeat (3) @(posedge iACLK);
      @(negedge iACLK);
      check_idle_outputs("reset");
      @(posedge iACLK); #1;
      iRST = 1'b0;

      run_program(16'h0010, 16'd3, 0, 16'hA000);
      run_program(16'h1234, 16'd8, 1, 16'h7E57);
      run_program(16'h0040, 16'd0, 0, 16'h0BAD);
      run_program(16'hFFFE, 16'd4, 0, 16'h3C3C);
      run_program(16'h0200, 16'd6, 3, 16'h1111);
      run_program(16'h0300, 16'd5, 0, 16'h2222);
      for (int n = 0; n < 6; n++) begin
         run_program(16'($urandom), 16'($urandom_range(1, 20)), 2, 16'($urandom));
      end
      reset_test();
`ifdef GPPCU_DISPATCH_ABORT_EN
      abort_test();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
